// File: rtl/array_sweep_pkg.sv
// -----------------------------------------------------------------------------
// array_sweep_pkg
// Shared types and helpers for the array_sweep generator:
//   state_e      - sweep controller states
//   sweep_value  - affine element value base + i + k + j*step, 32-bit
//   idx_width    - bit width of a counter over n values (minimum 1)
// -----------------------------------------------------------------------------
package array_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic [31:0] sweep_value(input logic [31:0] base,
                                                input logic [31:0] i,
                                                input logic [31:0] k,
                                                input logic [31:0] j,
                                                input logic [31:0] step);
        return base + i + k + j * step;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_sweep_idx.sv
// -----------------------------------------------------------------------------
// array_sweep_idx
// Nested element/iteration counters for array_sweep.
//   clk, rst      - clock, asynchronous active-high reset
//   init_i        - force i, k, j to zero (idle / sweep finished)
//   elem_adv_i    - step to the next element, i-major k-minor, wrapping
//   iter_adv_i    - increment iteration index j
//   hold_run_i    - count idle cycles between iterations; cleared when low
//   i_o, k_o, j_o - current indices
//   last_elem_o   - current element is (OUTER-1, INNER-1)
//   last_iter_o   - current iteration is ITERS-1
//   hold_last_o   - final hold cycle
// -----------------------------------------------------------------------------
module array_sweep_idx
    import array_sweep_pkg::*;
#(
    parameter int OUTER = 4,
    parameter int INNER = 2,
    parameter int ITERS = 2,
    parameter int HOLD  = 0,
    parameter int IW    = idx_width(OUTER),
    parameter int KW    = idx_width(INNER),
    parameter int JW    = $clog2(ITERS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_i,
    input  logic          elem_adv_i,
    input  logic          iter_adv_i,
    input  logic          hold_run_i,
    output logic [IW-1:0] i_o,
    output logic [KW-1:0] k_o,
    output logic [JW-1:0] j_o,
    output logic          last_elem_o,
    output logic          last_iter_o,
    output logic          hold_last_o
);

    localparam int HW = idx_width(HOLD + 1);
    localparam logic [IW-1:0] I_LAST    = IW'(OUTER - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(INNER - 1);
    localparam logic [JW-1:0] J_LAST    = JW'(ITERS - 1);
    // With HOLD=0 the hold state is never entered, so this value is unused.
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);

    logic [IW-1:0] i_q, i_d;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d;
    logic [HW-1:0] h_q, h_d;

    always_comb begin
        i_d = i_q;
        k_d = k_q;
        j_d = j_q;
        h_d = hold_run_i ? h_q + 1'b1 : '0;
        if (init_i) begin
            i_d = '0;
            k_d = '0;
            j_d = '0;
        end else begin
            if (elem_adv_i) begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            if (iter_adv_i) begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            k_q <= '0;
            j_q <= '0;
            h_q <= '0;
        end else begin
            i_q <= i_d;
            k_q <= k_d;
            j_q <= j_d;
            h_q <= h_d;
        end
    end

    assign i_o         = i_q;
    assign k_o         = k_q;
    assign j_o         = j_q;
    assign last_elem_o = (i_q == I_LAST) && (k_q == K_LAST);
    assign last_iter_o = (j_q == J_LAST);
    assign hold_last_o = (h_q == HOLD_LAST);

endmodule

// File: rtl/array_sweep.sv
// -----------------------------------------------------------------------------
// array_sweep
// Clocked generator that fills a packed array a and an unpacked array b with
// the pattern BASE + i + k + j*STEP, one element per cycle, for ITERS sweeps.
//   clk, rst     - clock, asynchronous active-high reset
//   start        - begin a sweep (sampled only when idle, wins over clear)
//   clear        - zero both arrays (honoured only when idle)
//   a            - packed   [OUTER][INNER][WIDTH] storage
//   b            - unpacked [OUTER][INNER] storage of WIDTH-bit words
//   busy         - sweep in progress
//   iter         - current iteration index j
//   frame_valid  - pulse: the last element of an iteration was just written
//   done         - pulse: final iteration complete
// -----------------------------------------------------------------------------
module array_sweep
    import array_sweep_pkg::*;
#(
    parameter int OUTER  = 4,
    parameter int INNER  = 2,
    parameter int WIDTH  = 16,
    parameter int ITERS  = 2,
    parameter int STEP   = 10,
    parameter int A_BASE = 1,
    parameter int B_BASE = 2,
    parameter int HOLD   = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   clear,
    output logic [OUTER-1:0][INNER-1:0][WIDTH-1:0] a,
    output logic [WIDTH-1:0]                       b [OUTER-1:0][INNER-1:0],
    output logic                                   busy,
    output logic [$clog2(ITERS+1)-1:0]             iter,
    output logic                                   frame_valid,
    output logic                                   done
);

    localparam int IW = idx_width(OUTER);
    localparam int KW = idx_width(INNER);
    localparam int JW = $clog2(ITERS + 1);

    state_e                                 state_q;
    logic                                   busy_q;
    logic                                   fv_q;
    logic                                   done_q;
    logic [OUTER-1:0][INNER-1:0][WIDTH-1:0] a_q;
    logic [WIDTH-1:0]                       b_q [OUTER-1:0][INNER-1:0];

    logic [IW-1:0]    idx_i;
    logic [KW-1:0]    idx_k;
    logic [JW-1:0]    idx_j;
    logic             last_elem, last_iter, hold_last;
    logic             cnt_init, cnt_elem, cnt_iter, cnt_hold;
    logic [WIDTH-1:0] a_val, b_val;

    // Counters sit at zero while idle and are cleared on the final write so
    // iter reads 0 again in the done cycle. Without hold cycles, j advances
    // together with the last write of an iteration.
    always_comb begin
        cnt_init = (state_q == ST_IDLE) ||
                   ((state_q == ST_WRITE) && last_elem && last_iter);
        cnt_elem = (state_q == ST_WRITE);
        cnt_iter = ((state_q == ST_WRITE) && last_elem && !last_iter && (HOLD == 0)) ||
                   ((state_q == ST_HOLD) && hold_last);
        cnt_hold = (state_q == ST_HOLD);
    end

    array_sweep_idx #(
        .OUTER (OUTER),
        .INNER (INNER),
        .ITERS (ITERS),
        .HOLD  (HOLD),
        .IW    (IW),
        .KW    (KW),
        .JW    (JW)
    ) u_idx (
        .clk         (clk),
        .rst         (rst),
        .init_i      (cnt_init),
        .elem_adv_i  (cnt_elem),
        .iter_adv_i  (cnt_iter),
        .hold_run_i  (cnt_hold),
        .i_o         (idx_i),
        .k_o         (idx_k),
        .j_o         (idx_j),
        .last_elem_o (last_elem),
        .last_iter_o (last_iter),
        .hold_last_o (hold_last)
    );

    // Values are formed in 32 bits and wrap to WIDTH.
    always_comb begin
        a_val = WIDTH'(sweep_value(32'(A_BASE), 32'(idx_i), 32'(idx_k), 32'(idx_j), 32'(STEP)));
        b_val = WIDTH'(sweep_value(32'(B_BASE), 32'(idx_i), 32'(idx_k), 32'(idx_j), 32'(STEP)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            for (int o = 0; o < OUTER; o++) begin
                for (int n = 0; n < INNER; n++) begin
                    b_q[o][n] <= '0;
                end
            end
        end else begin
            fv_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WRITE;
                        busy_q  <= 1'b1;
                    end else if (clear) begin
                        a_q <= '0;
                        for (int o = 0; o < OUTER; o++) begin
                            for (int n = 0; n < INNER; n++) begin
                                b_q[o][n] <= '0;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    a_q[idx_i][idx_k] <= a_val;
                    b_q[idx_i][idx_k] <= b_val;
                    if (last_elem) begin
                        fv_q <= 1'b1;
                        if (last_iter) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (HOLD > 0) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_last) begin
                        state_q <= ST_WRITE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign busy        = busy_q;
    assign iter        = idx_j;
    assign frame_valid = fv_q;
    assign done        = done_q;

endmodule

// File: tb/tb_array_sweep.sv
// -----------------------------------------------------------------------------
// tb_array_sweep
// Bench for array_sweep: a timeline model tracks the default-parameter
// instance every cycle; four more instances cover hold cycles, narrow words
// with and without wrap, and a 1x1 array with three iterations.
// -----------------------------------------------------------------------------
module tb_array_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- instance 0: defaults ----------------
    logic                    rst0, start0, clear0;
    logic [3:0][1:0][15:0]   a0;
    logic [15:0]             b0 [3:0][1:0];
    logic                    busy0, fv0, done0;
    logic [1:0]              iter0;

    array_sweep u0 (
        .clk(clk), .rst(rst0), .start(start0), .clear(clear0),
        .a(a0), .b(b0), .busy(busy0), .iter(iter0),
        .frame_valid(fv0), .done(done0)
    );

    // ---------------- instances 1..4 share one control set ----------------
    logic rst1, st1, cl1;

    logic [3:0][1:0][15:0] a1;
    logic [15:0]           b1 [3:0][1:0];
    logic                  busy1, fv1, done1;
    logic [1:0]            iter1;
    array_sweep #(.HOLD(3)) u1 (
        .clk(clk), .rst(rst1), .start(st1), .clear(cl1),
        .a(a1), .b(b1), .busy(busy1), .iter(iter1),
        .frame_valid(fv1), .done(done1)
    );

    logic [3:0][1:0][3:0] a2;
    logic [3:0]           b2 [3:0][1:0];
    logic                 busy2, fv2, done2;
    logic [1:0]           iter2;
    array_sweep #(.WIDTH(4)) u2 (
        .clk(clk), .rst(rst1), .start(st1), .clear(cl1),
        .a(a2), .b(b2), .busy(busy2), .iter(iter2),
        .frame_valid(fv2), .done(done2)
    );

    logic [3:0][1:0][3:0] a3;
    logic [3:0]           b3 [3:0][1:0];
    logic                 busy3, fv3, done3;
    logic [1:0]           iter3;
    array_sweep #(.WIDTH(4), .A_BASE(7)) u3 (
        .clk(clk), .rst(rst1), .start(st1), .clear(cl1),
        .a(a3), .b(b3), .busy(busy3), .iter(iter3),
        .frame_valid(fv3), .done(done3)
    );

    logic [0:0][0:0][15:0] a4;
    logic [15:0]           b4 [0:0][0:0];
    logic                  busy4, fv4, done4;
    logic [1:0]            iter4;
    array_sweep #(.OUTER(1), .INNER(1), .ITERS(3)) u4 (
        .clk(clk), .rst(rst1), .start(st1), .clear(cl1),
        .a(a4), .b(b4), .busy(busy4), .iter(iter4),
        .frame_valid(fv4), .done(done4)
    );

    // ---------------- timeline model of instance 0 ----------------
    // m_cyc counts edges since the start edge; element r of iteration jj is
    // written at edge 1 + jj*P + r with P = E + HOLD (HOLD = 0 here).
    localparam int M_OUTER = 4, M_INNER = 2, M_ITERS = 2, M_STEP = 10;
    localparam int M_E = M_OUTER * M_INNER;
    localparam int M_P = M_E;

    logic [3:0][1:0][15:0] ma;
    logic [15:0]           mb [3:0][1:0];
    logic                  m_busy, m_fv, m_done;
    int                    m_cyc, m_iter;

    always @(posedge clk or posedge rst0) begin : model
        int jj, r, ii, kk;
        if (rst0) begin
            m_busy = 1'b0; m_fv = 1'b0; m_done = 1'b0; m_cyc = 0; m_iter = 0;
            ma = '0;
            for (int x = 0; x < M_OUTER; x++)
                for (int y = 0; y < M_INNER; y++) mb[x][y] = '0;
        end else begin
            m_fv = 1'b0;
            m_done = 1'b0;
            if (!m_busy) begin
                if (start0) begin
                    m_busy = 1'b1;
                    m_cyc  = 0;
                    m_iter = 0;
                end else if (clear0) begin
                    ma = '0;
                    for (int x = 0; x < M_OUTER; x++)
                        for (int y = 0; y < M_INNER; y++) mb[x][y] = '0;
                end
            end else begin
                m_cyc++;
                jj = (m_cyc - 1) / M_P;
                r  = (m_cyc - 1) % M_P;
                if (r < M_E) begin
                    ii = r / M_INNER;
                    kk = r % M_INNER;
                    ma[ii][kk] = 16'(1 + ii + kk + jj * M_STEP);
                    mb[ii][kk] = 16'(2 + ii + kk + jj * M_STEP);
                    if (r == M_E - 1) begin
                        m_fv = 1'b1;
                        if (jj == M_ITERS - 1) begin
                            m_done = 1'b1;
                            m_busy = 1'b0;
                        end
                    end
                end
                m_iter = m_busy ? m_cyc / M_P : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst0) begin
            chk("u0_busy", 128'(busy0), 128'(m_busy));
            chk("u0_iter", 128'(iter0), 128'(m_iter));
            chk("u0_frame_valid", 128'(fv0), 128'(m_fv));
            chk("u0_done", 128'(done0), 128'(m_done));
            chk("u0_a", 128'(a0), 128'(ma));
            for (int x = 0; x < M_OUTER; x++)
                for (int y = 0; y < M_INNER; y++)
                    chk("u0_b", 128'(b0[x][y]), 128'(mb[x][y]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance 0 and wait for done; report cycle counts.
    task automatic run0(output int n_done, output int n_fv, output logic [15:0] fv_a00);
        int n;
        n = 0; n_fv = -1; fv_a00 = '0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        while (!done0 && n < 40) begin
            tick();
            n++;
            if (fv0 && n_fv < 0) begin
                n_fv   = n;
                fv_a00 = a0[0][0];
            end
        end
        n_done = n;
    endtask

    initial begin
        int n, nfv, d1, d2, d3, d4;
        logic [15:0] fa;
        logic seen, b1low;

        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; clear0 = 1'b0; st1 = 1'b0; cl1 = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 128'(busy0), 128'(0));
        chk("rst_iter", 128'(iter0), 128'(0));
        chk("rst_fv",   128'(fv0),   128'(0));
        chk("rst_done", 128'(done0), 128'(0));
        chk("rst_a",    128'(a0),    128'(0));
        chk("rst_b31",  128'(b0[3][1]), 128'(0));
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        // Run 1: defaults, single start.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("busy_rise", 128'(busy0), 128'(1));
        n = 0; seen = 1'b0;
        while (!done0 && n < 40) begin
            tick();
            n++;
            if (fv0 && !seen) begin
                seen = 1'b1;
                chk("fv1_cycle", 128'(n), 128'(8));
                chk("fv1_a31", 128'(a0[3][1]), 128'(5));
                chk("fv1_b31", 128'(b0[3][1]), 128'(6));
                chk("fv1_a00", 128'(a0[0][0]), 128'(1));
            end
        end
        chk("done_latency", 128'(n), 128'(16));
        chk("done_a00", 128'(a0[0][0]), 128'(11));
        chk("done_a31", 128'(a0[3][1]), 128'(15));
        chk("done_b31", 128'(b0[3][1]), 128'(16));
        chk("done_busy", 128'(busy0), 128'(0));
        tick();

        // Run 2: start and clear pulsed while busy are ignored.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 40) begin
            tick();
            n++;
            start0 = (n == 5);
            clear0 = (n == 7);
        end
        start0 = 1'b0; clear0 = 1'b0;
        chk("mid_latency", 128'(n), 128'(16));
        chk("mid_a31", 128'(a0[3][1]), 128'(15));

        // Run 3: start in the done cycle, no dead cycle.
        run0(n, nfv, fa);
        chk("b2b_latency", 128'(n), 128'(16));

        // clear in idle after done.
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        chk("clr_a",   128'(a0),       128'(0));
        chk("clr_b00", 128'(b0[0][0]), 128'(0));
        chk("clr_b31", 128'(b0[3][1]), 128'(0));
        tick();

        // Reset mid-sweep, after element 4 of iteration 1.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (13) tick();
        rst0 = 1'b1;
        #1;
        chk("mrst_busy", 128'(busy0), 128'(0));
        chk("mrst_iter", 128'(iter0), 128'(0));
        chk("mrst_done", 128'(done0), 128'(0));
        chk("mrst_a",    128'(a0),    128'(0));
        chk("mrst_b11",  128'(b0[1][1]), 128'(0));
        tick();
        rst0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            seen = seen | done0 | busy0;
        end
        chk("mrst_quiet", 128'(seen), 128'(0));
        run0(n, nfv, fa);
        chk("post_rst_latency", 128'(n), 128'(16));
        chk("post_rst_fv_cycle", 128'(nfv), 128'(8));
        chk("post_rst_fv_a00", 128'(fa), 128'(1));
        tick();

        // Instances 1..4 started together.
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        d1 = 0; d2 = 0; d3 = 0; d4 = 0; b1low = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (done1 && d1 == 0) d1 = c;
            if (done2 && d2 == 0) d2 = c;
            if (done3 && d3 == 0) d3 = c;
            if (done4 && d4 == 0) d4 = c;
            if (c < 19 && !busy1) b1low = 1'b1;
            if (c == 9)  chk("u1_iter_hold",   128'(iter1), 128'(0));
            if (c == 12) chk("u1_iter_write2", 128'(iter1), 128'(1));
            if (c == 8) begin
                chk("u2_fv_a31", 128'(a2[3][1]), 128'(5));
                chk("u3_fv_a31", 128'(a3[3][1]), 128'(11));
            end
            if (c == 16) begin
                chk("u2_a31_nowrap", 128'(a2[3][1]), 128'(15));
                chk("u2_b31_wrap",   128'(b2[3][1]), 128'(0));
                chk("u3_a31_wrap",   128'(a3[3][1]), 128'(5));
                chk("u3_b31_wrap",   128'(b3[3][1]), 128'(0));
            end
            if (c == 19) chk("u1_a31", 128'(a1[3][1]), 128'(15));
            if (c <= 4) begin
                chk("u4_fv",   128'(fv4),   128'(c <= 3));
                chk("u4_done", 128'(done4), 128'(c == 3));
            end
            if (c <= 3) chk("u4_a00", 128'(a4[0][0]), 128'(1 + 10 * (c - 1)));
        end
        chk("u1_done_latency", 128'(d1), 128'(19));
        chk("u1_busy_held",    128'(b1low), 128'(0));
        chk("u2_done_latency", 128'(d2), 128'(16));
        chk("u3_done_latency", 128'(d3), 128'(16));
        chk("u4_done_latency", 128'(d4), 128'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_sweep.md
# array_sweep

Parametrised stimulus block that owns one packed array `a[OUTER][INNER][WIDTH]` and one unpacked array `b[OUTER][INNER]` of WIDTH-bit words. On a start pulse it sweeps both arrays element by element over ITERS iterations using the affine value pattern base + i + k + j·STEP. It sits inside waveform test vectors as the dumped DUT: it generalises fixed-size, testbench-driven array fills into a clocked, handshaked, size-agnostic generator. It produces multi-cycle, per-element value changes for waveform tooling to trace.

## Interface
- OUTER, default 4: outer array dimension (index i), ≥1
- INNER, default 2: inner array dimension (index k), ≥1
- WIDTH, default 16: element width, ≥2
- ITERS, default 2: number of sweeps (index j), ≥1
- STEP, default 10: per-iteration value increment
- A_BASE, default 1 / B_BASE, default 2: pattern offsets for a / b
- HOLD, default 0: idle cycles inserted between iterations
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sweep; sampled only in IDLE
- clear  in  1  zero both arrays; honoured only in IDLE
- a  out  [OUTER-1:0][INNER-1:0][WIDTH-1:0]  packed array
- b  out  [WIDTH-1:0] b[OUTER-1:0][INNER-1:0]  unpacked array, same indexing
- busy  out  1  sweep in progress
- iter  out  $clog2(ITERS+1)  current iteration j
- frame_valid  out  1  one-cycle pulse: iteration j fully written
- done  out  1  one-cycle pulse: all iterations complete

## Operation
- Reset values: a, b all zero; busy 0; iter 0; frame_valid 0; done 0; state IDLE.
- States: IDLE, WRITE, HOLD.
  - IDLE: start=1 → WRITE, with i=k=j=0. Otherwise, clear=1 zeroes a and b. start has priority over clear when both are high.
  - WRITE: each cycle write one element. Order is i-major, k-minor: (0,0),(0,1),(1,0)…
    - Write value: a[i][k] = A_BASE+i+k+j·STEP and b[i][k] = B_BASE+i+k+j·STEP.
    - Compute in 32 bits, truncate to WIDTH (wrap, no saturation).
    - After the element (OUTER-1, INNER-1): pulse frame_valid.
    - If j = ITERS-1: also pulse done and go to IDLE.
    - Otherwise, if HOLD>0: go to HOLD.
    - Otherwise: increment j and stay in WRITE.
  - HOLD: count HOLD cycles, then increment j and go to WRITE.
- start and clear outside IDLE are ignored, with no queuing.
- Elements not yet written in iteration j keep their iteration j-1 values. Array contents persist after done.
- busy is high in WRITE and HOLD.
- iter shows j and returns to 0 when state re-enters IDLE.
- rst mid-sweep: everything immediately returns to reset values; no done pulse.

## Timing
- Let E = OUTER·INNER, and let edge t be the edge that samples start=1 in IDLE.
- busy rises after edge t.
- Element n (0-based) of iteration 0 is visible after edge t+1+n.
- frame_valid for iteration j is high in the cycle after its last element write, aligned with that write's visibility.
- Iteration j+1 first write lands HOLD+1 edges after iteration j's last write.
- Total: done is high in the cycle after edge t + ITERS·E + (ITERS-1)·HOLD. busy falls at that same edge.
- start back-to-back with done: start is sampled on the first IDLE cycle (the done cycle), giving no dead cycle.
- clear: arrays are zero the cycle after the sampling edge.

## Structure
- Package array_sweep_pkg holds:
  - the state enum (IDLE, WRITE, HOLD);
  - the 32-bit pattern function taking (base, i, k, j, step) and returning the value;
  - an index-width helper function.
- Sub-module array_sweep_idx: nested i/k/j counter with hold counter. Its outputs are the indices plus last_elem and last_iter flags.
- The top holds the FSM and the storage for a and b.

## Test plan
- Defaults, one start:
  - After the first frame_valid: a[3][1]=5, b[3][1]=6, a[0][0]=1.
  - At done: a[0][0]=11, a[3][1]=15, b[3][1]=16.
  - done arrives 16 cycles after the start edge.
- HOLD=3: done arrives at edge t+19. busy stays high throughout. iter reads 1 during the second WRITE phase.
- WIDTH=4, STEP=10, ITERS=2: the value for a[3][1] in iteration 1 is 15 (no wrap). Separately, with A_BASE=7, a[3][1] = (7+4+10) mod 16 = 5 (wrap).
- Mid-sweep events:
  - start pulsed mid-sweep: ignored, total cycle count unchanged.
  - clear while busy: ignored.
  - clear in IDLE after done: arrays read zero the next cycle.
- rst asserted mid-sweep at element 5 of iteration 1: all outputs zero immediately, no done. A new start then yields the full pattern from iteration 0.
- OUTER=1, INNER=1, ITERS=3: a[0][0] goes 1, 11, 21. frame_valid pulses on 3 consecutive cycles, and done coincides with the third pulse.
